// File: rtl/rr_reg_arbiter.sv
// rtl/rr_reg_arbiter.sv - round-robin arbiter owning a shared capture register
// Optional owner lock lets the current owner keep the register for up to MAX_LOCK grants.
module rr_reg_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          lock_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [DATA_W-1:0]           q_o,
    output logic [$clog2(NUM_REQ)-1:0]  q_owner_o,
    output logic                        q_valid_o
);
    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    typedef enum logic [1:0] {IDLE, GRANTED, LOCKED} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [OWN_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_hold;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [DATA_W-1:0]    r_q;
    logic [OWN_W-1:0]     r_owner;
    logic                 r_valid;

    logic                 w_lock_win;
    logic                 w_found;
    logic [OWN_W-1:0]     w_rot;
    logic [OWN_W-1:0]     w_win;
    logic                 w_grant;
    logic [CNT_W-1:0]     w_hold_nxt;
    logic [OWN_W-1:0]     w_ptr_nxt;
    logic [DATA_W-1:0]    w_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        w_found     = 1'b0;
        w_rot       = '0;
        w_hold_nxt  = '0;
        w_lock_win  = (r_state != IDLE) && req_i[r_owner] && lock_i[r_owner] &&
                      (r_hold < CNT_W'(MAX_LOCK - 1));
        // Scan starts at ptr, which already points one past the last winner.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_i[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_rot   = OWN_W'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
        w_win   = w_lock_win ? r_owner : w_rot;
        w_grant = w_lock_win || w_found;
        if (w_lock_win) begin
            w_state_nxt = LOCKED;
            w_hold_nxt  = r_hold + CNT_W'(1);
        end else if (w_found) begin
            w_state_nxt = GRANTED;
        end
        w_ptr_nxt = (w_win == OWN_W'(NUM_REQ - 1)) ? '0 : w_win + OWN_W'(1);
        w_data    = data_i[int'(w_win)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
            r_q     <= '0;
            r_owner <= '0;
            r_valid <= 1'b0;
        end else if (w_grant) begin
            r_gnt   <= NUM_REQ'(1) << w_win;
            r_q     <= w_data;
            r_owner <= w_win;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
        end else begin
            // Idle: the captured value and owner stay visible, only grant/valid drop.
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end
    end

    assign gnt_o     = r_gnt;
    assign q_o       = r_q;
    assign q_owner_o = r_owner;
    assign q_valid_o = r_valid;
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb/tb_rr_reg_arbiter.sv - scoreboard bench for rr_reg_arbiter
// Driver pushes hand-computed expectations; a monitor pops one per cycle after the edge.
module tb_rr_reg_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  lock = '0;
    logic [31:0] data = 32'h13121110;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        valid;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] own;
        logic       vld;
    } exp_t;

    exp_t  sb[$];
    string nq[$];
    int    checks = 0;
    int    failures = 0;

    localparam logic [31:0] D = 32'h13121110;

    rr_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_LOCK(4)) dut (
        .clk(clk), .reset(reset), .req_i(req), .lock_i(lock), .data_i(data),
        .gnt_o(gnt), .q_o(q), .q_owner_o(owner), .q_valid_o(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n = nq.pop_front();
                chk({n, ".gnt"}, {4'h0, gnt}, {4'h0, e.gnt});
                chk({n, ".q"}, q, e.q);
                chk({n, ".owner"}, {6'h0, owner}, {6'h0, e.own});
                chk({n, ".valid"}, {7'h0, valid}, {7'h0, e.vld});
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                        input logic [3:0] eg, input logic [7:0] eq, input logic [1:0] eo,
                        input logic ev, input string nm);
        @(negedge clk);
        req  = r;
        lock = l;
        data = d;
        sb.push_back('{gnt: eg, q: eq, own: eo, vld: ev});
        nq.push_back(nm);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset.gnt", {4'h0, gnt}, 8'h00);
        chk("reset.q", q, 8'h00);
        chk("reset.owner", {6'h0, owner}, 8'h00);
        chk("reset.valid", {7'h0, valid}, 8'h00);

        for (int i = 0; i < 8; i++)
            step(4'b1111, 4'b0000, D, 4'b0001 << (i % 4), 8'h10 + 8'(i % 4), 2'(i % 4), 1'b1, "rotate");

        step(4'b0100, 4'b0000, D, 4'b0100, 8'h12, 2'd2, 1'b1, "sparse.setup");
        step(4'b0011, 4'b0000, D, 4'b0001, 8'h10, 2'd0, 1'b1, "sparse.wrap0");
        step(4'b0011, 4'b0000, D, 4'b0010, 8'h11, 2'd1, 1'b1, "sparse.wrap1");

        step(4'b1000, 4'b0000, D, 4'b1000, 8'h13, 2'd3, 1'b1, "lock.setup");
        for (int i = 0; i < 4; i++)
            step(4'b0101, 4'b0001, D, 4'b0001, 8'h10, 2'd0, 1'b1, "lock.hold");
        step(4'b0101, 4'b0001, D, 4'b0100, 8'h12, 2'd2, 1'b1, "lock.expire");
        step(4'b0101, 4'b0001, D, 4'b0001, 8'h10, 2'd0, 1'b1, "lock.back");

        for (int i = 0; i < 10; i++)
            step(4'b0010, 4'b0010, D, 4'b0010, 8'h11, 2'd1, 1'b1, "sole");

        step(4'b0100, 4'b0000, 32'h13A51110, 4'b0100, 8'hA5, 2'd2, 1'b1, "idle.grant");
        for (int i = 0; i < 3; i++)
            step(4'b0000, 4'b0000, D, 4'b0000, 8'hA5, 2'd2, 1'b0, "idle.hold");
        step(4'b1111, 4'b0000, D, 4'b1000, 8'h13, 2'd3, 1'b1, "idle.resume");

        step(4'b0001, 4'b0000, 32'h1312115A, 4'b0001, 8'h5A, 2'd0, 1'b1, "rst.setup");
        @(posedge clk);
        #3;
        chk("rst.pre_q", q, 8'h5A);
        chk("rst.pre_valid", {7'h0, valid}, 8'h01);
        reset = 1'b1;
        #1;
        chk("rst.async_gnt", {4'h0, gnt}, 8'h00);
        chk("rst.async_q", q, 8'h00);
        chk("rst.async_valid", {7'h0, valid}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        req = 4'b0000;
        data = D;
        step(4'b1111, 4'b0000, D, 4'b0001, 8'h10, 2'd0, 1'b1, "rst.first");

        step(4'b0000, 4'b0000, D, 4'b0000, 8'h10, 2'd0, 1'b0, "end.idle");
        repeat (3) @(posedge clk);
        #2;
        chk("sb.drained", 8'(sb.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_reg_arbiter.md
# rr_reg_arbiter

Round-robin arbiter that shares a single capture register among NUM_REQ requesters. Each cycle it selects one requesting source, latches that source's data into the shared register, and reports the owner and a grant. An optional per-requester lock lets the current owner keep the register for a bounded number of consecutive cycles. It sits in front of the team's flop-based storage as the sequencer that decides which source writes it.

## Interface
- NUM_REQ, 4: number of requesters; 2..16.
- DATA_W, 8: data width per requester.
- MAX_LOCK, 4: maximum consecutive grants to one owner via lock; ≥1.
- OWN_W: derived, $clog2(NUM_REQ).
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_i  in  NUM_REQ  per-requester request.
- lock_i  in  NUM_REQ  per-requester lock; only meaningful for the current owner.
- data_i  in  NUM_REQ*DATA_W  packed data; requester k occupies bits [k*DATA_W +: DATA_W].
- gnt_o  out  NUM_REQ  registered one-hot grant; all-zero when idle.
- q_o  out  DATA_W  shared register contents.
- q_owner_o  out  OWN_W  index of the requester that last wrote q_o.
- q_valid_o  out  1  high for each cycle following a grant edge.

## Operation
- Internal state:
  - ptr (OWN_W): highest-priority index for rotation.
  - hold_cnt: counts 0..MAX_LOCK-1.
  - FSM: IDLE, GRANTED, LOCKED.
- Reset values:
  - gnt_o=0, q_o=0, q_owner_o=0, q_valid_o=0.
  - ptr=0, hold_cnt=0, state=IDLE.
- Winner selection at each posedge, using sampled req_i/lock_i:
  - Lock win: state≠IDLE, req_i[q_owner_o]=1, lock_i[q_owner_o]=1 and hold_cnt<MAX_LOCK-1. Winner is q_owner_o; hold_cnt++; next state LOCKED.
  - Otherwise, rotation: first k with req_i[k]=1, scanning ptr, ptr+1, …, wrapping from NUM_REQ-1 to 0. hold_cnt←0; next state GRANTED.
  - No request: gnt_o←0, q_valid_o←0, state←IDLE. q_o and q_owner_o hold their values; ptr and hold_cnt are unchanged.
- On any grant to winner w:
  - gnt_o←onehot(w), q_o←data_i[w], q_owner_o←w, q_valid_o←1.
  - ptr←(w+1) mod NUM_REQ.
- Lock expiry:
  - After MAX_LOCK consecutive grants to the owner, rotation applies. Because ptr already points past the owner, the other requesters are served first.
  - If the owner is the sole requester, it wins by rotation. hold_cnt restarts at 0 and a new lock window begins.
- lock_i on a non-owner, or lock_i without req_i, is ignored.
- Handshake:
  - A requester holds req_i until it sees its gnt_o bit.
  - Dropping req_i before that withdraws the request with no side effect.
  - A requester that keeps req_i high after its grant re-enters rotation.
- Reset mid-operation: outputs clear asynchronously in the same cycle. The first grant occurs at the first posedge after reset deasserts with any req_i high, and rotation starts at index 0.

## Timing
- Latency: 1 cycle. Requests sampled at edge k produce gnt_o, q_o, q_owner_o and q_valid_o valid after edge k.
- Throughput: one grant per cycle; no bubble between consecutive grants.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Fairness: with all requesters continuously active and no lock, each is granted exactly once every NUM_REQ cycles.
- With lock, the worst-case wait for any requester is (NUM_REQ-1)*MAX_LOCK cycles.

## Test plan
- Reset: assert reset mid-cycle while q_valid_o=1 and q_o=0x5A. Required: gnt_o=0, q_o=0x00 and q_valid_o=0 immediately; after release with req_i=4'b1111, first gnt_o=4'b0001.
- Full rotation: req_i=4'b1111 held for 8 cycles, data_i[k]=0x10+k, lock_i=0. Required: gnt_o sequence 0001,0010,0100,1000,0001,…; q_o 0x10,0x11,0x12,0x13,0x10,…
- Sparse and wrap: ptr=3 after a grant to index 2, req_i=4'b0011. Required: gnt_o=0001 and then 0010; q_owner_o 0 then 1.
- Lock limit: req_i=4'b0101 with lock_i[0]=1 held, MAX_LOCK=4. Required: gnt_o=0001 for 4 consecutive cycles, then 0100, then 0001.
- Sole locked owner: req_i=4'b0010 with lock_i=4'b0010 for 10 cycles. Required: gnt_o=0010 every cycle with q_valid_o continuously 1.
- Idle hold: grant index 2 with data 0xA5, then req_i=0 for 3 cycles. Required: gnt_o=0 and q_valid_o=0, q_o=0xA5 and q_owner_o=2 held; next req_i=4'b1111 grants index 3.
